// File: rtl/repvgg_row_engine.sv
// RepVGG row engine: fused 3x3 + 1x1 (+ identity) conv on one channel, one pixel in / one result out.
// Optional ACT_RELU_EN: clamp negative saturated results to zero.
//
// state  | meaning
// IDLE   | waiting for start; mode latched on start
// LOAD_W | accepting w00..w22 then w1x1 (10 words)
// FILL   | writing image row 0 into the line buffer, no output (3x3 only)
// RUN    | streaming rows; 3x3 inserts one right-pad bubble after each row
// FLUSH  | emitting the last image row against a zero bottom row (3x3 only)
// DONE   | waiting for the final result to drain, then pulse done
module repvgg_row_engine #(
  parameter int DW = 32,
  parameter int FW = 8,
  parameter int W  = 56,
  parameter int H  = 56
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode_i,
  input  logic          wht_valid,
  input  logic [DW-1:0] wht_i,
  output logic          wht_ready,
  input  logic          fmap_valid,
  input  logic [DW-1:0] fmap_i,
  output logic          fmap_ready,
  output logic          out_valid,
  output logic [DW-1:0] data_o,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(W);
  localparam int RW = $clog2(H);
  // Sum carries full product precision so large operands saturate instead of wrapping.
  localparam int SW = 2 * DW + 4;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t state_q, state_d;

  logic [1:0]           mode_q;
  logic [3:0]           wcnt_q;
  logic [CW-1:0]        col_q;
  logic [RW-1:0]        row_q;
  logic [IW-1:0]        col_idx;
  logic signed [DW-1:0] wts_q [9];
  logic signed [DW-1:0] w1_q;
  logic signed [DW-1:0] lb_a [W];
  logic signed [DW-1:0] lb_b [W];
  logic signed [DW-1:0] win_q [3][3];
  logic signed [DW-1:0] win_n [3][3];
  logic signed [DW-1:0] new_col [3];
  logic signed [DW-1:0] centre;
  logic signed [SW-1:0] acc;
  logic [DW-1:0]        res;
  logic                 out_valid_q;
  logic [DW-1:0]        data_q;

  logic can_out, accept_w, accept_px, step, gen_out, adv, wrap;
  logic col_last, col_pad, row_last, is_1x1;

  assign col_idx  = col_q[IW-1:0];
  assign is_1x1   = mode_q[0];
  assign can_out  = !out_valid_q || out_ready;
  assign col_last = (col_q == CW'(W - 1));
  assign col_pad  = (col_q == CW'(W));
  assign row_last = (row_q == RW'(H - 1));

  assign accept_w  = wht_valid && wht_ready;
  assign accept_px = fmap_valid && fmap_ready;
  // A 3x3 step shifts one window column: a real pixel, or a zero pad column in the bubble/FLUSH.
  assign step    = ((state_q == S_RUN) && !is_1x1 && (col_pad ? can_out : accept_px)) ||
                   ((state_q == S_FLUSH) && can_out);
  assign gen_out = (step && (col_q != '0)) || ((state_q == S_RUN) && is_1x1 && accept_px);
  assign adv     = ((state_q == S_FILL) && accept_px) || ((state_q == S_RUN) && is_1x1 && accept_px) || step;
  assign wrap    = ((state_q == S_FILL) || is_1x1) ? col_last : col_pad;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD_W;
      S_LOAD_W: if (accept_w && (wcnt_q == 4'd9)) state_d = is_1x1 ? S_RUN : S_FILL;
      S_FILL:   if (accept_px && col_last) state_d = S_RUN;
      S_RUN: begin
        if (is_1x1) begin
          if (accept_px && col_last && row_last) state_d = S_DONE;
        end else if (step && col_pad && row_last) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH:  if (step && col_pad) state_d = S_DONE;
      S_DONE:   if (!out_valid_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wht_ready  = (state_q == S_LOAD_W);
    fmap_ready = ((state_q == S_FILL) || ((state_q == S_RUN) && (is_1x1 || !col_pad))) && can_out;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE) && !out_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= '0;
      wcnt_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        mode_q <= mode_i;
        wcnt_q <= '0;
        col_q  <= '0;
        row_q  <= '0;
      end
      if (accept_w) wcnt_q <= wcnt_q + 4'd1;
      if (adv) begin
        if (wrap) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_w) begin
      if (wcnt_q == 4'd9) w1_q <= wht_i;
      else                wts_q[wcnt_q] <= wht_i;
    end
    if ((state_q == S_FILL) && accept_px) begin
      lb_a[col_idx] <= '0;
      lb_b[col_idx] <= fmap_i;
    end
    if (step) begin
      win_q <= win_n;
      if ((state_q == S_RUN) && !col_pad) begin
        lb_a[col_idx] <= lb_b[col_idx];
        lb_b[col_idx] <= fmap_i;
      end
    end
  end

  // Window columns hold c-1, c, c+1 of the result being produced; column 0 starts with left padding.
  always_comb begin
    for (int i = 0; i < 3; i++) new_col[i] = '0;
    if (!col_pad) begin
      new_col[0] = lb_a[col_idx];
      new_col[1] = lb_b[col_idx];
      new_col[2] = (state_q == S_RUN) ? fmap_i : '0;
    end
    for (int i = 0; i < 3; i++) begin
      if (col_q == '0) begin
        win_n[i][0] = '0;
        win_n[i][1] = '0;
      end else begin
        win_n[i][0] = win_q[i][1];
        win_n[i][1] = win_q[i][2];
      end
      win_n[i][2] = new_col[i];
    end
  end

  function automatic logic signed [SW-1:0] mulq(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] ax, bx, p;
    ax = (2*DW)'(a);
    bx = (2*DW)'(b);
    p  = ax * bx;
    return SW'(p >>> FW);
  endfunction

  always_comb begin
    centre = is_1x1 ? fmap_i : win_n[1][1];
    acc    = mulq(w1_q, centre);
    if (mode_q[1]) acc = acc + SW'(centre);
    if (!is_1x1) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          acc = acc + mulq(win_n[i][j], wts_q[i*3+j]);
    end
    if (acc > SAT_MAX)      res = SAT_MAX[DW-1:0];
    else if (acc < SAT_MIN) res = SAT_MIN[DW-1:0];
    else                    res = acc[DW-1:0];
`ifdef ACT_RELU_EN
    if (res[DW-1]) res = '0;
`else
    res = res;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else if (gen_out) begin
      out_valid_q <= 1'b1;
      data_q      <= res;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign data_o    = data_q;

endmodule
